// File: rtl/rf_wb_arbiter_if.sv
// Writeback arbiter bus: two writeback requesters, issue-stage scoreboard
// queries and the register-file write port, bundled for rf_wb_arbiter.
interface rf_wb_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    // ALU writeback request
    logic              alu_wb_valid;
    logic              alu_wb_ready;
    logic [ADDR_W-1:0] alu_wb_rd;
    logic [DATA_W-1:0] alu_wb_data;

    // load-unit writeback request
    logic              ld_wb_valid;
    logic              ld_wb_ready;
    logic [ADDR_W-1:0] ld_wb_rd;
    logic [DATA_W-1:0] ld_wb_data;

    // issue-stage destination allocation and source hazard lookup
    logic              alloc_valid;
    logic [ADDR_W-1:0] alloc_rd;
    logic              alloc_ready;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic              rs1_busy;
    logic              rs2_busy;
    logic              rs1_fwd_valid;
    logic [DATA_W-1:0] rs1_fwd_data;
    logic              rs2_fwd_valid;
    logic [DATA_W-1:0] rs2_fwd_data;

    // register-file write port
    logic              rf_regWEn;
    logic [ADDR_W-1:0] rf_rd;
    logic [DATA_W-1:0] rf_DataD;

    // Requester / issue side (execute, memory and issue stages)
    modport master (
        output alu_wb_valid, alu_wb_rd, alu_wb_data,
        output ld_wb_valid, ld_wb_rd, ld_wb_data,
        output alloc_valid, alloc_rd, rs1, rs2,
        input  alu_wb_ready, ld_wb_ready, alloc_ready,
        input  rs1_busy, rs2_busy,
        input  rs1_fwd_valid, rs1_fwd_data, rs2_fwd_valid, rs2_fwd_data,
        input  rf_regWEn, rf_rd, rf_DataD
    );

    // Arbiter side
    modport slave (
        input  alu_wb_valid, alu_wb_rd, alu_wb_data,
        input  ld_wb_valid, ld_wb_rd, ld_wb_data,
        input  alloc_valid, alloc_rd, rs1, rs2,
        output alu_wb_ready, ld_wb_ready, alloc_ready,
        output rs1_busy, rs2_busy,
        output rs1_fwd_valid, rs1_fwd_data, rs2_fwd_valid, rs2_fwd_data,
        output rf_regWEn, rf_rd, rf_DataD
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin sharing of the single register-file write port
// between the ALU and load writeback sources, with a registered write and a
// per-register pending-write scoreboard for issue-stage RAW/WAW stalls.
// Optional feature macro: RF_WB_FWD_EN (forward the committing value to the
// issue-stage source lookups, hiding the commit-cycle stall).
module rf_wb_arbiter #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    rf_wb_arbiter_if.slave bus
);
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LD  = 1'b1
    } src_e;

    src_e                rr_ptr;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_set;
    logic [NUM_REGS-1:0] busy_clr;

    logic                alu_gnt;
    logic                ld_gnt;
    logic                conflict;
    logic                alloc_fire;

    logic                rf_we_q;
    logic [ADDR_W-1:0]   rf_rd_q;
    logic [DATA_W-1:0]   rf_data_q;

    // Grant: a lone requester wins; on a conflict the round-robin pointer decides
    always_comb begin
        conflict = bus.alu_wb_valid && bus.ld_wb_valid;
        alu_gnt  = bus.alu_wb_valid && (!bus.ld_wb_valid || (rr_ptr == SRC_ALU));
        ld_gnt   = bus.ld_wb_valid  && (!bus.alu_wb_valid || (rr_ptr == SRC_LD));
    end

    assign bus.alu_wb_ready = alu_gnt;
    assign bus.ld_wb_ready  = ld_gnt;

    // Pointer only moves on conflicts so a lone requester never loses its turn
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= SRC_ALU;
        end else if (conflict) begin
            rr_ptr <= (rr_ptr == SRC_ALU) ? SRC_LD : SRC_ALU;
        end
    end

    // Registered write port; x0 writes are passed through with the enable low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q   <= 1'b0;
            rf_rd_q   <= '0;
            rf_data_q <= '0;
        end else if (alu_gnt) begin
            rf_we_q   <= (bus.alu_wb_rd != '0);
            rf_rd_q   <= bus.alu_wb_rd;
            rf_data_q <= bus.alu_wb_data;
        end else if (ld_gnt) begin
            rf_we_q   <= (bus.ld_wb_rd != '0);
            rf_rd_q   <= bus.ld_wb_rd;
            rf_data_q <= bus.ld_wb_data;
        end else begin
            rf_we_q   <= 1'b0;
        end
    end

    assign bus.rf_regWEn = rf_we_q;
    assign bus.rf_rd     = rf_rd_q;
    assign bus.rf_DataD  = rf_data_q;

    // Allocation is refused while the destination still has a write in flight
    always_comb begin
        bus.alloc_ready = (bus.alloc_rd == '0) || !busy[bus.alloc_rd];
        alloc_fire      = bus.alloc_valid && bus.alloc_ready;
    end

    // Scoreboard set/clear masks; bit 0 is never set so x0 always reads idle
    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (alloc_fire) begin
            busy_set = (NUM_REGS'(1) << bus.alloc_rd) & ~NUM_REGS'(1);
        end
        if (rf_we_q) begin
            busy_clr = NUM_REGS'(1) << rf_rd_q;
        end
    end

    // Scoreboard update: a new allocation wins over a same-cycle commit clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~busy_clr) | busy_set;
        end
    end

`ifdef RF_WB_FWD_EN
    logic rs1_hit;
    logic rs2_hit;

    // Committing value bypasses the scoreboard for matching issue sources
    always_comb begin
        rs1_hit           = rf_we_q && (rf_rd_q == bus.rs1) && (bus.rs1 != '0);
        rs2_hit           = rf_we_q && (rf_rd_q == bus.rs2) && (bus.rs2 != '0);
        bus.rs1_busy      = busy[bus.rs1] && !rs1_hit;
        bus.rs2_busy      = busy[bus.rs2] && !rs2_hit;
        bus.rs1_fwd_valid = rs1_hit;
        bus.rs2_fwd_valid = rs2_hit;
        bus.rs1_fwd_data  = rs1_hit ? rf_data_q : '0;
        bus.rs2_fwd_data  = rs2_hit ? rf_data_q : '0;
    end
`else
    // No bypass: sources stay busy through the commit cycle
    always_comb begin
        bus.rs1_busy      = busy[bus.rs1];
        bus.rs2_busy      = busy[bus.rs2];
        bus.rs1_fwd_valid = 1'b0;
        bus.rs2_fwd_valid = 1'b0;
        bus.rs1_fwd_data  = '0;
        bus.rs2_fwd_data  = '0;
    end
`endif

endmodule
